voice_phase_scheduler: RTL and testbench
========================================

Name: voice_phase_scheduler

Overview:
- Time-multiplexed phase-accumulator sequencer for the synth voices.
- On each audio sample tick it walks every voice slot and performs three steps per voice:
  - selects that voice's 32-bit phase increment from the external phase_incr PIO mux;
  - updates the voice's phase accumulator;
  - streams (voice, phase) to the downstream wavetable/mixer over a valid/ready handshake.
- Sits between the Nios-written phase_incr PIO bank and the wave lookup. Replaces per-voice NCOs with one shared adder.

Parameters:
- NUM_VOICES, 31, number of voice slots / phase_incr PIOs.
- PHASE_W, 32, phase accumulator and increment width.
- IDX_W, 5, voice index width; must satisfy 2**IDX_W >= NUM_VOICES.

Ports:
- clk_clk  in  1  system clock (50 MHz).
- reset_reset_n  in  1  asynchronous active-low reset.
- sample_tick  in  1  one-cycle pulse at the audio sample rate; starts a frame.
- voice_en  in  NUM_VOICES  per-voice key-down mask, sampled at frame start.
- incr_sel  out  IDX_W  registered select for the external phase_incr mux.
- incr_data  in  PHASE_W  selected increment; combinational from the mux.
- out_valid  out  1  phase sample valid.
- out_ready  in  1  downstream accept.
- out_voice  out  IDX_W  voice index of the current sample.
- out_phase  out  PHASE_W  updated phase of that voice.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse after the last voice is accepted.
- overrun  out  1  one-cycle pulse when sample_tick arrives while busy.

Behaviour:
- Reset values: all outputs 0, all accumulators 0, idx=0, state IDLE. Reset mid-frame aborts the frame immediately; no partial handshake survives.
- FSM states: IDLE, FETCH, UPDATE, EMIT, DONE.
- IDLE:
  - sample_tick -> latch voice_en into en_q; idx<=0; incr_sel<=0; busy<=1; go to FETCH.
- FETCH (1 cycle):
  - incr_sel is stable and the mux settles; go to UPDATE.
- UPDATE (1 cycle):
  - If en_q[idx]: phase[idx] <= phase[idx] + incr_data, modulo 2**PHASE_W (carry discarded, natural wrap).
  - Else: phase[idx] <= 0. Released voices restart at phase 0.
  - Load out_phase with the new value and out_voice<=idx; go to EMIT.
- EMIT:
  - out_valid=1. out_voice and out_phase are held stable until out_valid && out_ready.
  - On accept: out_valid<=0. If idx==NUM_VOICES-1, go to DONE; else idx<=idx+1, incr_sel<=idx+1, go to FETCH.
- DONE (1 cycle):
  - frame_done=1, busy<=0, go to IDLE.
- Latency: with out_ready tied high, 3 cycles per voice, and tick to frame_done = 3*NUM_VOICES+2 cycles (95 for 31 voices).
- Boundary conditions:
  - sample_tick while busy (any state other than IDLE): tick dropped, overrun pulses, current frame unaffected.
  - sample_tick in the same cycle as the DONE state: counts as busy, so it is dropped and flagged.
  - Changes to voice_en mid-frame are ignored until the next tick.
  - out_ready held low stalls the frame indefinitely; no timeout.

Optional Feature:
- Macro: VOICE_SKIP_EN.
- Defined:
  - Voices with en_q[idx]=0 are cleared to phase 0 in UPDATE but produce no EMIT; the FSM advances straight to the next FETCH.
  - A frame with no enabled voices lasts 2*NUM_VOICES+2 cycles and emits nothing.
  - frame_done still pulses once per frame.
- Undefined: every voice is emitted each frame; disabled voices emit out_phase=0.

Decomposition:
- Package synth_pkg holds:
  - NUM_VOICES, PHASE_W, IDX_W constants;
  - the scheduler state enum;
  - typedef phase_t (logic [PHASE_W-1:0]);
  - typedef voice_idx_t.
- Sub-module phase_acc_bank: NUM_VOICES x PHASE_W register array with one read and one write port, plus asynchronous clear on reset_reset_n. Keeps the FSM file small and allows later migration to M9K.

Test Plan:
1. Reset, then one tick with voice_en=all 1s, incr_data=idx+1, out_ready=1 -> 31 beats with out_phase=1..31 in voice order; frame_done at cycle 95 after the tick.
2. Voice 3 with increment 32'hC000_0000, two ticks -> voice 3 out_phase 32'hC000_0000, then 32'h8000_0000 (wrap, no carry).
3. Voice 3 enabled for 2 ticks with incr=100, then voice_en[3]=0 -> phases 100, 200, then 0 (skip off) or no beat for voice 3 (VOICE_SKIP_EN).
4. out_ready low for 10 cycles during voice 5 -> out_voice=5 and out_phase held constant; no change to voice 6 accumulator until accept.
5. Second sample_tick 20 cycles into a frame -> overrun pulses once; frame completes normally; exactly one frame_done.
6. reset_reset_n asserted mid-EMIT -> out_valid, busy, and all phases 0 immediately; the next tick restarts at voice 0.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared constants and types for the voice phase scheduler.
// No ports. Holds voice count, phase/index widths, the scheduler state
// enum and the phase/voice-index typedefs used by the scheduler and
// its accumulator bank.
package synth_pkg;

    localparam int unsigned NUM_VOICES = 31;
    localparam int unsigned PHASE_W    = 32;
    localparam int unsigned IDX_W      = 5;

    typedef logic [PHASE_W-1:0] phase_t;
    typedef logic [IDX_W-1:0]   voice_idx_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_UPDATE = 3'd2,
        ST_EMIT   = 3'd3,
        ST_DONE   = 3'd4
    } sched_state_e;

    localparam voice_idx_t LAST_VOICE = voice_idx_t'(NUM_VOICES - 1);

endpackage : synth_pkg

// File: rtl/phase_acc_bank.sv
// Per-voice phase accumulator storage: NUM_VOICES x PHASE_W registers,
// one combinational read port and one synchronous write port.
// Ports:
//   clk        - system clock
//   rst_n      - asynchronous active-low clear of every accumulator
//   rd_idx_i   - read voice index
//   rd_data_c  - accumulator of rd_idx_i (combinational)
//   wr_en_i    - write strobe
//   wr_idx_i   - write voice index
//   wr_data_i  - value written to wr_idx_i
module phase_acc_bank
    import synth_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  voice_idx_t rd_idx_i,
    output phase_t     rd_data_c,
    input  logic       wr_en_i,
    input  voice_idx_t wr_idx_i,
    input  phase_t     wr_data_i
);

    phase_t acc_q [NUM_VOICES];

    // Read port
    assign rd_data_c = acc_q[rd_idx_i];

    // Write port with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_VOICES); i++) begin
                acc_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            acc_q[wr_idx_i] <= wr_data_i;
        end
    end

endmodule : phase_acc_bank

// File: rtl/voice_phase_scheduler.sv
// Time-multiplexed phase accumulator sequencer. On each sample_tick it
// walks all voice slots: selects the voice's increment from the external
// phase_incr mux, updates the shared accumulator bank and streams
// (voice, phase) downstream over valid/ready.
// Optional build macro: VOICE_SKIP_EN - disabled voices are cleared but
// not emitted.
// Ports:
//   clk_clk        - system clock
//   reset_reset_n  - asynchronous active-low reset
//   sample_tick    - frame start pulse
//   voice_en       - key-down mask, latched at frame start
//   incr_sel       - registered select for the external increment mux
//   incr_data      - selected increment (combinational from the mux)
//   out_valid      - phase sample valid
//   out_ready      - downstream accept
//   out_voice      - voice index of the current sample
//   out_phase      - updated phase of that voice
//   busy           - frame in progress
//   frame_done     - one-cycle pulse after the last voice of a frame
//   overrun        - one-cycle pulse for a tick dropped while busy
module voice_phase_scheduler
    import synth_pkg::*;
(
    input  logic                  clk_clk,
    input  logic                  reset_reset_n,
    input  logic                  sample_tick,
    input  logic [NUM_VOICES-1:0] voice_en,
    output logic [IDX_W-1:0]      incr_sel,
    input  logic [PHASE_W-1:0]    incr_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [IDX_W-1:0]      out_voice,
    output logic [PHASE_W-1:0]    out_phase,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  overrun
);

    sched_state_e          state_q;
    voice_idx_t            idx_q;
    logic [NUM_VOICES-1:0] en_q;

    phase_t rd_phase_c;
    phase_t new_phase_c;
    logic   wr_en_c;
    logic   last_c;

    // Released voices restart at zero; enabled voices wrap modulo 2**PHASE_W
    always_comb begin
        new_phase_c = '0;
        if (en_q[idx_q]) begin
            new_phase_c = rd_phase_c + incr_data;
        end
    end

    assign wr_en_c = (state_q == ST_UPDATE);
    assign last_c  = (idx_q == LAST_VOICE);

    phase_acc_bank u_bank (
        .clk       (clk_clk),
        .rst_n     (reset_reset_n),
        .rd_idx_i  (idx_q),
        .rd_data_c (rd_phase_c),
        .wr_en_i   (wr_en_c),
        .wr_idx_i  (idx_q),
        .wr_data_i (new_phase_c)
    );

    // Scheduler FSM with registered outputs
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            en_q       <= '0;
            incr_sel   <= '0;
            out_valid  <= 1'b0;
            out_voice  <= '0;
            out_phase  <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            // Any tick outside IDLE (DONE included) is dropped and flagged
            overrun    <= sample_tick && (state_q != ST_IDLE);

            case (state_q)
                ST_IDLE: begin
                    if (sample_tick) begin
                        en_q     <= voice_en;
                        idx_q    <= '0;
                        incr_sel <= '0;
                        busy     <= 1'b1;
                        state_q  <= ST_FETCH;
                    end
                end

                // incr_sel was registered last cycle; give the mux a cycle
                ST_FETCH: begin
                    state_q <= ST_UPDATE;
                end

                ST_UPDATE: begin
`ifdef VOICE_SKIP_EN
                    if (!en_q[idx_q]) begin
                        if (last_c) begin
                            frame_done <= 1'b1;
                            state_q    <= ST_DONE;
                        end else begin
                            idx_q    <= voice_idx_t'(idx_q + 1'b1);
                            incr_sel <= voice_idx_t'(idx_q + 1'b1);
                            state_q  <= ST_FETCH;
                        end
                    end else begin
                        out_voice <= idx_q;
                        out_phase <= new_phase_c;
                        out_valid <= 1'b1;
                        state_q   <= ST_EMIT;
                    end
`else
                    out_voice <= idx_q;
                    out_phase <= new_phase_c;
                    out_valid <= 1'b1;
                    state_q   <= ST_EMIT;
`endif
                end

                // Hold voice/phase until the downstream accepts
                ST_EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (last_c) begin
                            frame_done <= 1'b1;
                            state_q    <= ST_DONE;
                        end else begin
                            idx_q    <= voice_idx_t'(idx_q + 1'b1);
                            incr_sel <= voice_idx_t'(idx_q + 1'b1);
                            state_q  <= ST_FETCH;
                        end
                    end
                end

                ST_DONE: begin
                    busy    <= 1'b0;
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : voice_phase_scheduler

// File: tb/tb_voice_phase_scheduler.sv
// Randomized self-checking bench for voice_phase_scheduler. A frame-level
// reference model predicts the ordered beat stream, frame length, overrun
// and frame_done counts from the voice enables and increments.
`timescale 1ns/1ps
module tb_voice_phase_scheduler;

    localparam int NV = 31;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sample_tick = 1'b0;
    logic [NV-1:0] voice_en = '0;
    logic [4:0]    incr_sel;
    logic [31:0]   incr_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [4:0]    out_voice;
    logic [31:0]   out_phase;
    logic          busy;
    logic          frame_done;
    logic          overrun;

    // External phase_incr PIO bank and its mux
    logic [31:0] incr_tab [32];
    assign incr_data = incr_tab[incr_sel];

    // Reference state: phase of each voice after the last modelled frame
    logic [31:0] model_phase [NV];
    // Last phase the DUT emitted per voice in the most recent frame
    logic [31:0] seen_phase [NV];
    bit          seen_ok [NV];

    int n_checks = 0;
    int n_errors = 0;

    always #10 clk = ~clk;

    voice_phase_scheduler dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .sample_tick   (sample_tick),
        .voice_en      (voice_en),
        .incr_sel      (incr_sel),
        .incr_data     (incr_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_voice     (out_voice),
        .out_phase     (out_phase),
        .busy          (busy),
        .frame_done    (frame_done),
        .overrun       (overrun)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] wrap_add(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] s;
        s = 64'(a) + 64'(b);
        return 32'(s % 64'h1_0000_0000);
    endfunction

    task automatic rand_incr();
        for (int v = 0; v < 32; v++) incr_tab[v] = $urandom;
    endtask

    // stall_mode: 0 ready high, 1 random ready, 2 hold voice 5 for 10 cycles.
    // extra_tick: 0 none, >0 cycle of a second tick, -1 tick during DONE.
    task automatic run_frame(input logic [NV-1:0] en, input int stall_mode,
                             input int extra_tick, input bit chk_lat);
        logic [31:0] ev[$];
        logic [31:0] ep[$];
        logic [31:0] hv, hp, xv, xp;
        int  cyc, fd_cnt, ov_cnt, exp_cyc, stall5, tick_cyc;
        bit  done, held, rdy;

        for (int v = 0; v < NV; v++) begin
            model_phase[v] = en[v] ? wrap_add(model_phase[v], incr_tab[v]) : 32'd0;
            seen_ok[v] = 0;
`ifdef VOICE_SKIP_EN
            if (en[v]) begin
                ev.push_back(32'(v));
                ep.push_back(model_phase[v]);
            end
`else
            ev.push_back(32'(v));
            ep.push_back(model_phase[v]);
`endif
        end
        // Tick cycle + FETCH/UPDATE per voice + EMIT per beat + DONE
        exp_cyc  = 2 * NV + 2 + ev.size() + ((stall_mode == 2) ? 10 : 0);
        tick_cyc = (extra_tick < 0) ? exp_cyc : extra_tick;

        @(negedge clk);
        sample_tick = 1'b1;
        voice_en    = en;
        out_ready   = 1'b1;
        cyc = 1; fd_cnt = 0; ov_cnt = 0; stall5 = 0;
        done = 0; held = 0;
        hv = '0; hp = '0;

        while (!done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            sample_tick = (cyc == tick_cyc);
            voice_en    = NV'($urandom);
            if (overrun) ov_cnt++;
            if (frame_done) begin
                fd_cnt++;
                done = 1;
                if (chk_lat) chk("frame_len", 64'(cyc), 64'(exp_cyc));
            end
            if (held) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_voice", 64'(out_voice), 64'(hv));
                chk("hold_phase", 64'(out_phase), 64'(hp));
            end
            rdy = 1'b1;
            if (stall_mode == 1) rdy = ($urandom_range(0, 2) != 0);
            if (stall_mode == 2 && out_valid && out_voice == 5'd5 && stall5 < 10) begin
                rdy = 1'b0;
                stall5++;
            end
            out_ready = rdy;
            if (out_valid && !done) begin
                if (rdy) begin
                    held = 0;
                    if (ev.size() == 0) begin
                        chk("extra_beat", 64'(out_voice), 64'hFFFF);
                    end else begin
                        xv = ev.pop_front();
                        xp = ep.pop_front();
                        chk("beat_voice", 64'(out_voice), 64'(xv));
                        chk("beat_phase", 64'(out_phase), 64'(xp));
                    end
                    if (int'(out_voice) < NV) begin
                        seen_phase[out_voice] = out_phase;
                        seen_ok[out_voice]    = 1;
                    end
                end else begin
                    held = 1;
                    hv = 32'(out_voice);
                    hp = out_phase;
                end
            end
        end
        if (!done) chk("frame_timeout", 64'(cyc), 64'd0);

        @(negedge clk);
        sample_tick = 1'b0;
        out_ready   = 1'b1;
        if (overrun) ov_cnt++;
        chk("busy_after", 64'(busy), 64'd0);
        chk("frame_done_cnt", 64'(fd_cnt), 64'd1);
        chk("overrun_cnt", 64'(ov_cnt), (extra_tick != 0) ? 64'd1 : 64'd0);
        chk("beats_missing", 64'(ev.size()), 64'd0);
    endtask

    initial begin
        logic [NV-1:0] en;

        for (int v = 0; v < NV; v++) model_phase[v] = '0;
        rand_incr();

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_sel", 64'(incr_sel), 64'd0);
        chk("rst_phase", 64'(out_phase), 64'd0);
        chk("rst_done", 64'(frame_done), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // All voices, incr = idx+1
        for (int v = 0; v < 32; v++) incr_tab[v] = 32'(v + 1);
        run_frame('1, 0, 0, 1);
        chk("v0_first", 64'(seen_phase[0]), 64'd1);
        chk("v30_first", 64'(seen_phase[30]), 64'd31);

        // Empty frame clears every voice
        run_frame('0, 0, 0, 1);

        // Wrap without carry on voice 3
        rand_incr();
        incr_tab[3] = 32'hC000_0000;
        en = NV'($urandom) | NV'(1 << 3);
        run_frame(en, 0, 0, 1);
        chk("v3_c0", 64'(seen_phase[3]), 64'hC000_0000);
        en = NV'($urandom) | NV'(1 << 3);
        run_frame(en, 0, 0, 1);
        chk("v3_wrap", 64'(seen_phase[3]), 64'h8000_0000);

        // Key release restarts voice 3 at zero
        run_frame(NV'($urandom) & ~NV'(1 << 3), 0, 0, 1);
        incr_tab[3] = 32'd100;
        run_frame(NV'($urandom) | NV'(1 << 3), 0, 0, 1);
        chk("v3_100", 64'(seen_phase[3]), 64'd100);
        run_frame(NV'($urandom) | NV'(1 << 3), 0, 0, 1);
        chk("v3_200", 64'(seen_phase[3]), 64'd200);
        run_frame(NV'($urandom) & ~NV'(1 << 3), 0, 0, 1);
`ifdef VOICE_SKIP_EN
        chk("v3_skipped", 64'(seen_ok[3]), 64'd0);
`else
        chk("v3_released", 64'(seen_phase[3]), 64'd0);
`endif

        // Back-pressure on voice 5, then random back-pressure
        rand_incr();
        run_frame('1, 2, 0, 1);
        rand_incr();
        run_frame(NV'($urandom), 1, 0, 0);

        // Second tick mid-frame and tick during DONE
        rand_incr();
        run_frame('1, 0, 20, 1);
        rand_incr();
        run_frame(NV'($urandom), 0, -1, 1);

        // Reset in the middle of an EMIT stall
        @(negedge clk);
        sample_tick = 1'b1;
        voice_en    = '1;
        out_ready   = 1'b0;
        @(negedge clk);
        sample_tick = 1'b0;
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_phase", 64'(out_phase), 64'd0);
        chk("mid_rst_sel", 64'(incr_sel), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int v = 0; v < NV; v++) model_phase[v] = '0;
        rand_incr();
        run_frame('1, 0, 0, 1);
        chk("post_rst_v0", 64'(seen_phase[0]), 64'(incr_tab[0]));

        // Random frames
        for (int k = 0; k < 6; k++) begin
            rand_incr();
            run_frame(NV'($urandom), (k % 2), 0, (k % 2) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_voice_phase_scheduler
